// File: rtl/fir_ctrl_fsm.sv
// fir_ctrl_fsm: sequencing controller for the FIR buffer/multiplier/accumulator chain.
// Latency: result valid N_TAPS+3+MUL_LAT cycles after the input handshake; probka_ready only in IDLE.
// Backpressure: holds the result in OUT until wynik_ready; optional FIR_SAMPLE_CNT_EN adds licznik_probek.
module fir_ctrl_fsm #(
  parameter int N_TAPS  = 16,
  parameter int ADDR_W  = 4,
  parameter int MUL_LAT = 1
) (
  input  logic              clk_b,
  input  logic              rst,
  input  logic              probka_valid,
  output logic              probka_ready,
  output logic              FSM_wr_probka,
  output logic [ADDR_W-1:0] FSM_adr_probki,
  output logic [ADDR_W-1:0] FSM_adr_wsp,
  output logic              FSM_reset_Acc,
  output logic              FSM_Acc_en,
  output logic              FSM_Acc_zapis,
  output logic              wynik_valid,
`ifdef FIR_SAMPLE_CNT_EN
  output logic [15:0]       licznik_probek,
`endif
  input  logic              wynik_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_DRAIN,
    S_SAVE,
    S_OUT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(N_TAPS - 1);
  // Only compared while in DRAIN, which is never entered when MUL_LAT is 0.
  localparam logic [1:0]        LAST_DRAIN = 2'(MUL_LAT - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;     // slot that the next sample is written to
  logic [ADDR_W-1:0] rd_ptr;     // sample address for the current tap, walks backwards
  logic [ADDR_W-1:0] tap_k;      // coefficient index
  logic [1:0]        drain_cnt;
  logic              mac_issue;

  assign mac_issue = (state == S_MAC);

  // State register.
  always_ff @(posedge clk_b) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; inputs only steer transitions, never outputs.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (probka_valid) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_MAC;
      S_MAC:   if (tap_k == LAST_IDX) state_nxt = (MUL_LAT == 0) ? S_SAVE : S_DRAIN;
      S_DRAIN: if (drain_cnt == LAST_DRAIN) state_nxt = S_SAVE;
      S_SAVE:  state_nxt = S_OUT;
      S_OUT:   if (wynik_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address counters: rd_ptr decrements with an explicit wrap so N_TAPS need not be a power of two,
  // and both counters stop on the last tap so DRAIN keeps showing the final addresses.
  always_ff @(posedge clk_b) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tap_k     <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          rd_ptr <= wr_ptr;
          tap_k  <= '0;
        end
        S_MAC: begin
          drain_cnt <= '0;
          if (tap_k != LAST_IDX) begin
            tap_k  <= tap_k + 1'b1;
            rd_ptr <= (rd_ptr == '0) ? LAST_IDX : rd_ptr - 1'b1;
          end
        end
        S_DRAIN: drain_cnt <= drain_cnt + 1'b1;
        S_SAVE:  wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
        default: ;
      endcase
    end
  end

  // Output decode from the registered state and counters.
  always_comb begin
    probka_ready   = 1'b0;
    FSM_wr_probka  = 1'b0;
    FSM_reset_Acc  = 1'b0;
    FSM_Acc_zapis  = 1'b0;
    wynik_valid    = 1'b0;
    FSM_adr_probki = '0;
    FSM_adr_wsp    = '0;
    case (state)
      S_IDLE: probka_ready = 1'b1;
      S_LOAD: begin
        FSM_wr_probka  = 1'b1;
        FSM_reset_Acc  = 1'b1;
        FSM_adr_probki = wr_ptr;
      end
      S_MAC, S_DRAIN: begin
        FSM_adr_probki = rd_ptr;
        FSM_adr_wsp    = tap_k;
      end
      S_SAVE:  FSM_Acc_zapis = 1'b1;
      S_OUT:   wynik_valid = 1'b1;
      default: ;
    endcase
  end

  // Accumulate enable follows the tap issue by the multiplier latency.
  generate
    if (MUL_LAT == 0) begin : g_acc_direct
      assign FSM_Acc_en = mac_issue;
    end else begin : g_acc_pipe
      logic [MUL_LAT-1:0] acc_sr;
      // Shift the issue flag through MUL_LAT stages; cleared on reset so an aborted run leaves no tail.
      always_ff @(posedge clk_b) begin
        if (rst) begin
          acc_sr <= '0;
        end else begin
          acc_sr[0] <= mac_issue;
          for (int j = 1; j < MUL_LAT; j++) acc_sr[j] <= acc_sr[j-1];
        end
      end
      assign FSM_Acc_en = acc_sr[MUL_LAT-1];
    end
  endgenerate

`ifdef FIR_SAMPLE_CNT_EN
  // Count completed result handshakes, wrapping naturally at 16 bits.
  always_ff @(posedge clk_b) begin
    if (rst)                                licznik_probek <= '0;
    else if (state == S_OUT && wynik_ready) licznik_probek <= licznik_probek + 16'd1;
  end
`endif

endmodule
